// File: rtl/mux_pkg.sv
// Shared definitions for the registered stream multiplexer.
//   MODE_DIRECT / MODE_RR : values of the mode input
//   DEFAULT_BUS_SIZE      : default data width per channel
//   DEFAULT_NUM_CH        : default channel count
//   clog2()               : ceiling log2, used to size channel indices
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    localparam int unsigned DEFAULT_BUS_SIZE = 16;
    localparam int unsigned DEFAULT_NUM_CH   = 16;

    // Ceiling log2; returns at least 1 so index vectors are never zero-width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        if (res == 0) begin
            res = 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter (combinational).
// Grants the first requesting channel found while searching ptr, ptr+1, ...
// modulo NUM_CH.
//   req       in   NUM_CH  request vector
//   ptr       in   IDX_W   highest-priority channel this cycle
//   grant     out  NUM_CH  one-hot grant (all zero when no request)
//   grant_idx out  IDX_W   index of the granted channel (0 when none)
//   any       out  1       at least one request present
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
    parameter int unsigned IDX_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    // Rotating priority search; the first hit from ptr onwards wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            logic [IDX_W-1:0] k;
            k = IDX_W'((32'(ptr) + off) % NUM_CH);
            if (!any && req[k]) begin
                any       = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = k;
            end
        end
    end

endmodule

// File: rtl/mux_reg_stream.sv
// Registered N-channel stream multiplexer with valid/ready handshaking.
// DIRECT mode selects a channel by one-hot sel; RR mode arbitrates round-robin
// over ch_valid. Multi-hot selects in DIRECT mode are refused (never OR-merged)
// and counted in a saturating error counter with a sticky flag.
//   clk        in   1                 rising-edge clock
//   rst        in   1                 synchronous active-high reset
//   ch_data    in   NUM_CH*BUS_SIZE   flattened channel data
//   ch_valid   in   NUM_CH            per-channel valid
//   ch_ready   out  NUM_CH            per-channel accept (combinational, <=1 hot)
//   sel        in   NUM_CH            one-hot select (DIRECT mode)
//   mode       in   1                 0 = DIRECT, 1 = RR
//   out_data   out  BUS_SIZE          registered selected data
//   out_ch     out  IDX_W             source channel of out_data
//   out_valid  out  1                 output valid
//   out_ready  in   1                 downstream accept
//   sel_err    out  1                 sticky illegal-select flag
//   err_count  out  ERR_CNT_W         saturating illegal-select count
//   err_clr    in   1                 clears sel_err and err_count
module mux_reg_stream
    import mux_pkg::*;
#(
    parameter int unsigned BUS_SIZE  = DEFAULT_BUS_SIZE,
    parameter int unsigned NUM_CH    = DEFAULT_NUM_CH,
    parameter int unsigned IDX_W     = clog2(NUM_CH),
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH*BUS_SIZE-1:0] ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    output logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH-1:0]          sel,
    input  logic                       mode,
    output logic [BUS_SIZE-1:0]        out_data,
    output logic [IDX_W-1:0]           out_ch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sel_err,
    output logic [ERR_CNT_W-1:0]       err_count,
    input  logic                       err_clr
);

    logic                can_load;
    logic                sel_multi;
    logic                sel_one;
    logic [IDX_W-1:0]    dir_idx;
    logic [NUM_CH-1:0]   dir_grant;

    logic [IDX_W-1:0]    ptr;
    logic [NUM_CH-1:0]   rr_grant;
    logic [IDX_W-1:0]    rr_idx;
    logic                rr_any;

    logic [NUM_CH-1:0]   grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                xfer;
    logic                err_event;
    logic [BUS_SIZE-1:0] sel_data;
    logic [IDX_W-1:0]    ptr_next;

    // Output stage can accept new data when empty or draining this cycle.
    assign can_load = !out_valid || out_ready;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign sel_multi = |(sel & (sel - NUM_CH'(1)));
    assign sel_one   = (sel != '0) && !sel_multi;

    // One-hot to index encode; meaningful only when sel_one is high.
    always_comb begin
        dir_idx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                dir_idx = IDX_W'(i);
            end
        end
    end

    assign dir_grant = sel_one ? sel : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_arbiter (
        .req       (ch_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any       (rr_any)
    );

    // Grant source follows the current mode in the same cycle.
    always_comb begin
        if (mode == MODE_RR) begin
            grant     = rr_grant;
            grant_idx = rr_idx;
            grant_any = rr_any;
        end else begin
            grant     = dir_grant;
            grant_idx = dir_idx;
            grant_any = sel_one;
        end
    end

    assign ch_ready  = (rst || !can_load) ? '0 : grant;
    assign xfer      = can_load && grant_any && ch_valid[grant_idx];
    assign err_event = (mode == MODE_DIRECT) && sel_multi && can_load;
    assign sel_data  = ch_data[32'(grant_idx)*BUS_SIZE +: BUS_SIZE];

    // Pointer moves just past the winner, wrapping at the last channel.
    assign ptr_next = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + IDX_W'(1);

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= sel_data;
                out_ch    <= grant_idx;
                out_valid <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Illegal-select tracking; a new event takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err   <= 1'b0;
            err_count <= '0;
        end else if (err_event) begin
            sel_err <= 1'b1;
            if (err_clr) begin
                err_count <= ERR_CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            sel_err   <= 1'b0;
            err_count <= '0;
        end
    end

endmodule

// File: tb/tb_mux_reg_stream.sv
// Self-checking bench for mux_reg_stream: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mux_reg_stream;

    localparam int NB = 16;
    localparam int NC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*NB-1:0] ch_data;
    logic [NC-1:0]    ch_valid;
    logic [NC-1:0]    ch_ready;
    logic [NC-1:0]    sel;
    logic             mode;
    logic [NB-1:0]    out_data;
    logic [3:0]       out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             sel_err;
    logic [7:0]       err_count;
    logic             err_clr;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Behavioural model state
    bit       m_valid;
    int       m_data;
    int       m_ch;
    int       m_ptr;
    bit       m_err;
    int       m_cnt;

    mux_reg_stream dut (
        .clk       (clk),
        .rst       (rst),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_count (err_count),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel the rules award this cycle, or -1 for none.
    function automatic int model_grant();
        if (mode == 1'b0) begin
            if ($countones(sel) != 1) return -1;
            for (int k = 0; k < NC; k++) if (sel[k]) return k;
            return -1;
        end
        for (int off = 0; off < NC; off++) begin
            int k;
            k = (m_ptr + off) % NC;
            if (ch_valid[k]) return k;
        end
        return -1;
    endfunction

    // Model update at the clock edge from the inputs seen at that edge.
    always @(posedge clk) begin
        int  g;
        bit  can;
        bit  ev;
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
        end else begin
            can = !m_valid || out_ready;
            g   = model_grant();
            ev  = (mode == 1'b0) && ($countones(sel) >= 2) && can;
            if (can && g >= 0 && ch_valid[g]) begin
                m_data  = int'(ch_data[g*NB +: NB]);
                m_ch    = g;
                m_valid = 1;
                if (mode) m_ptr = (g + 1) % NC;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (ev) begin
                m_err = 1;
                m_cnt = err_clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (err_clr) begin
                m_err = 0;
                m_cnt = 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NC-1:0] exp_rdy;
            int g;
            g = model_grant();
            exp_rdy = '0;
            if (!rst && (!m_valid || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
            chk("ch_ready",  32'(ch_ready),  32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_data",  32'(out_data),  32'(m_data));
            chk("out_ch",    32'(out_ch),    32'(m_ch));
            chk("sel_err",   32'(sel_err),   32'(m_err));
            chk("err_count", 32'(err_count), 32'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [NB-1:0] v);
        ch_data[k*NB +: NB] = v;
    endtask

    initial begin
        rst = 1; ch_valid = '0; sel = '0; mode = 0; out_ready = 0; err_clr = 0;
        for (int k = 0; k < NC; k++) set_ch(k, NB'(16'h1000 + k));
        cyc(); cyc();
        // 1. reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sel_err",   32'(sel_err),   32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_ch_ready",  32'(ch_ready),  32'd0);
        chk_en = 1;

        // 2. DIRECT selection
        rst = 0; set_ch(0, 16'h0002); set_ch(15, 16'h0080);
        ch_valid = '1; sel = 16'h8000; out_ready = 1;
        cyc();
        chk("d_ch15_data", 32'(out_data), 32'h0080);
        chk("d_ch15_ch",   32'(out_ch),   32'd15);
        chk("d_ch15_vld",  32'(out_valid), 32'd1);
        sel = 16'h0001;
        cyc();
        chk("d_ch0_data", 32'(out_data), 32'h0002);
        chk("d_ch0_ch",   32'(out_ch),   32'd0);

        // 3. stall holds the output
        set_ch(3, 16'hBEEF); sel = 16'h0008;
        cyc();
        chk("st_load", 32'(out_data), 32'hBEEF);
        set_ch(4, 16'h4444); sel = 16'h0010; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_ready", 32'(ch_ready), 32'd0);
            cyc();
            chk("st_hold", 32'(out_data), 32'hBEEF);
        end
        out_ready = 1;
        #1;
        chk("st_release_ready", 32'(ch_ready), 32'h0010);
        cyc();
        chk("st_ch4_data", 32'(out_data), 32'h4444);
        chk("st_ch4_ch",   32'(out_ch),   32'd4);

        // 4. illegal select, then clear coinciding with an event
        sel = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ill_ready", 32'(ch_ready), 32'd0);
            cyc();
        end
        chk("ill_sel_err",   32'(sel_err),   32'd1);
        chk("ill_err_count", 32'(err_count), 32'd3);
        err_clr = 1; sel = 16'h0005;
        cyc();
        chk("clr_evt_count", 32'(err_count), 32'd1);
        chk("clr_evt_flag",  32'(sel_err),   32'd1);
        err_clr = 0;

        // 5. saturation
        sel = 16'h0003;
        repeat (300) cyc();
        chk("sat_count", 32'(err_count), 32'hFF);
        chk("sat_flag",  32'(sel_err),   32'd1);
        err_clr = 1; sel = '0;
        cyc();
        chk("clr_count", 32'(err_count), 32'd0);
        chk("clr_flag",  32'(sel_err),   32'd0);
        err_clr = 0;

        // 6. round robin
        mode = 1; ch_valid = '1; sel = 16'hFFFF;
        for (int i = 0; i <= 16; i++) begin
            cyc();
            chk("rr_seq", 32'(out_ch), 32'(i % 16));
        end
        ch_valid = 16'h0020;
        cyc();
        chk("rr_only5", 32'(out_ch), 32'd5);
        ch_valid = 16'h0024;
        cyc(); chk("rr_p6_a", 32'(out_ch), 32'd2);
        cyc(); chk("rr_p6_b", 32'(out_ch), 32'd5);
        cyc(); chk("rr_p6_c", 32'(out_ch), 32'd2);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            for (int k = 0; k < NC; k++) set_ch(k, NB'($urandom));
            ch_valid  = NC'($urandom) & NC'($urandom);
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            err_clr   = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 3);
            if (r == 0)      sel = '0;
            else if (r == 3) sel = NC'($urandom);
            else begin
                sel = '0;
                sel[$urandom_range(0, NC-1)] = 1'b1;
            end
            cyc();
        end

        @(posedge clk);
        #1;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
